// File: rtl/bist_march_ctrl.sv
// March C- self-test sequencer for a 64x8 single-port SRAM with registered read address.
// Drives the RAM pins, checks every read, and reports pass/fail plus first-failure data.
module bist_march_ctrl #(
   parameter int                ADDR_W       = 6,
   parameter int                DATA_W       = 8,
   parameter int                DEPTH        = 64,
   parameter logic [DATA_W-1:0] PATTERN      = '0,
   parameter bit                STOP_ON_FAIL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_re,
   input  logic [DATA_W-1:0] ram_q,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [7:0]        err_cnt,
   output logic [2:0]        fail_elem,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_exp,
   output logic [DATA_W-1:0] fail_act
);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CMP, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_elem, w_elem_nxt, w_elem_inc;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic [DATA_W-1:0] r_data, w_data_nxt;
   logic              r_re, w_re_nxt;
   logic              r_busy, r_done, r_pass, r_fail, w_fail_nxt;
   logic [7:0]        r_err, w_err_nxt;
   logic [2:0]        r_fail_elem, w_fail_elem_nxt;
   logic [ADDR_W-1:0] r_fail_addr, w_fail_addr_nxt;
   logic [DATA_W-1:0] r_fail_exp, w_fail_exp_nxt, r_fail_act, w_fail_act_nxt;
   logic              w_mis, w_clear, w_term;

   function automatic logic f_down(input logic [2:0] elem);
      return (elem == 3'd3) || (elem == 3'd4);
   endfunction

   // Value written by each element; M5 never writes.
   function automatic logic [DATA_W-1:0] f_wval(input logic [2:0] elem);
      return (elem == 3'd1 || elem == 3'd3) ? ~PATTERN : PATTERN;
   endfunction

   function automatic logic [DATA_W-1:0] f_rval(input logic [2:0] elem);
      return (elem == 3'd2 || elem == 3'd4) ? ~PATTERN : PATTERN;
   endfunction

   assign w_elem_inc = r_elem + 3'd1;
   assign w_mis      = (r_state == S_CMP) && (ram_q != f_rval(r_elem));
   assign w_term     = f_down(r_elem) ? (r_addr == '0) : (r_addr == LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_elem_nxt  = r_elem;
      w_addr_nxt  = r_addr;
      w_clear     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_WR;
               w_elem_nxt  = 3'd0;
               w_addr_nxt  = '0;
               w_clear     = 1'b1;
            end
         end
         S_WR: begin
            if (r_addr == LAST) begin
               w_state_nxt = S_RD;
               w_elem_nxt  = 3'd1;
               w_addr_nxt  = '0;
            end else begin
               w_addr_nxt  = r_addr + 1'b1;
            end
         end
         S_RD: w_state_nxt = S_CMP;
         S_CMP: begin
            if (STOP_ON_FAIL && w_mis) begin
               w_state_nxt = S_DONE;
            end else if (w_term) begin
               if (r_elem == 3'd5) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_RD;
                  w_elem_nxt  = w_elem_inc;
                  w_addr_nxt  = f_down(w_elem_inc) ? LAST : '0;
               end
            end else begin
               w_state_nxt = S_RD;
               w_addr_nxt  = f_down(r_elem) ? r_addr - 1'b1 : r_addr + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // RAM pins are computed for the upcoming cycle so they leave straight from flops.
      w_re_nxt   = !((w_state_nxt == S_WR) || (w_state_nxt == S_CMP && w_elem_nxt != 3'd5));
      w_data_nxt = w_re_nxt ? r_data : f_wval(w_elem_nxt);

      w_fail_nxt      = r_fail | w_mis;
      w_err_nxt       = (w_mis && r_err != 8'hFF) ? r_err + 8'd1 : r_err;
      w_fail_elem_nxt = r_fail_elem;
      w_fail_addr_nxt = r_fail_addr;
      w_fail_exp_nxt  = r_fail_exp;
      w_fail_act_nxt  = r_fail_act;
      if (w_clear) begin
         w_fail_nxt      = 1'b0;
         w_err_nxt       = '0;
         w_fail_elem_nxt = '0;
         w_fail_addr_nxt = '0;
         w_fail_exp_nxt  = '0;
         w_fail_act_nxt  = '0;
      end else if (w_mis && !r_fail) begin
         w_fail_elem_nxt = r_elem;
         w_fail_addr_nxt = r_addr;
         w_fail_exp_nxt  = f_rval(r_elem);
         w_fail_act_nxt  = ram_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_elem      <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_re        <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_fail      <= 1'b0;
         r_err       <= '0;
         r_fail_elem <= '0;
         r_fail_addr <= '0;
         r_fail_exp  <= '0;
         r_fail_act  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_elem      <= w_elem_nxt;
         r_addr      <= w_addr_nxt;
         r_data      <= w_data_nxt;
         r_re        <= w_re_nxt;
         r_busy      <= (w_state_nxt == S_WR) || (w_state_nxt == S_RD) || (w_state_nxt == S_CMP);
         r_done      <= (w_state_nxt == S_DONE);
         r_pass      <= (w_state_nxt == S_DONE) && !w_fail_nxt;
         r_fail      <= w_fail_nxt;
         r_err       <= w_err_nxt;
         r_fail_elem <= w_fail_elem_nxt;
         r_fail_addr <= w_fail_addr_nxt;
         r_fail_exp  <= w_fail_exp_nxt;
         r_fail_act  <= w_fail_act_nxt;
      end
   end

   assign ram_data  = r_data;
   assign ram_addr  = r_addr;
   assign ram_re    = r_re;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign fail      = r_fail;
   assign err_cnt   = r_err;
   assign fail_elem = r_fail_elem;
   assign fail_addr = r_fail_addr;
   assign fail_exp  = r_fail_exp;
   assign fail_act  = r_fail_act;

endmodule

// File: tb/tb_bist_march_ctrl.sv
// Directed bench for bist_march_ctrl: two instances (run-to-end and stop-on-fail),
// each with its own behavioural 64x8 RAM and an optional bit0 stuck-at-1 on word 0x2A.
module tb_bist_march_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       fault;

   logic [7:0] ram_data,  ram_q,  err_cnt,  fail_exp,  fail_act;
   logic [5:0] ram_addr,  fail_addr;
   logic [2:0] fail_elem;
   logic       ram_re, busy, done, pass, fail;

   logic [7:0] s_ram_data, s_ram_q, s_err_cnt, s_fail_exp, s_fail_act;
   logic [5:0] s_ram_addr, s_fail_addr;
   logic [2:0] s_fail_elem;
   logic       s_ram_re, s_busy, s_done, s_pass, s_fail;

   int n_checks = 0;
   int n_fail   = 0;
   int busy_n, done_at, s_busy_n, s_done_at;

   always #5 clk = ~clk;

   bist_march_ctrl #(.STOP_ON_FAIL(1'b0)) u_dut (
      .clk(clk), .rst(rst), .start(start),
      .ram_data(ram_data), .ram_addr(ram_addr), .ram_re(ram_re), .ram_q(ram_q),
      .busy(busy), .done(done), .pass(pass), .fail(fail), .err_cnt(err_cnt),
      .fail_elem(fail_elem), .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_act(fail_act)
   );

   bist_march_ctrl #(.STOP_ON_FAIL(1'b1)) u_dut_s (
      .clk(clk), .rst(rst), .start(start),
      .ram_data(s_ram_data), .ram_addr(s_ram_addr), .ram_re(s_ram_re), .ram_q(s_ram_q),
      .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail), .err_cnt(s_err_cnt),
      .fail_elem(s_fail_elem), .fail_addr(s_fail_addr), .fail_exp(s_fail_exp), .fail_act(s_fail_act)
   );

   // RAM models: synchronous write when re=0, registered read address.
   logic [7:0] mem   [64];
   logic [7:0] s_mem [64];
   logic [5:0] raddr, s_raddr;

   always @(posedge clk) begin
      if (!ram_re) mem[ram_addr] <= ram_data;
      raddr <= ram_addr;
      if (!s_ram_re) s_mem[s_ram_addr] <= s_ram_data;
      s_raddr <= s_ram_addr;
   end

   assign ram_q   = mem[raddr]     | ((fault && raddr   == 6'h2A) ? 8'h01 : 8'h00);
   assign s_ram_q = s_mem[s_raddr] | ((fault && s_raddr == 6'h2A) ? 8'h01 : 8'h00);

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   // Runs one test from start; cycle c is sampled at the negedge inside busy cycle c.
   task automatic run_test(input int glitch_cyc, input int abort_cyc);
      busy_n = 0; done_at = -1; s_busy_n = 0; s_done_at = -1;
      pulse_start();
      for (int c = 0; c <= 710; c++) begin
         @(negedge clk);
         if (c == abort_cyc) begin
            rst = 1'b1;
            #1;
            chk("abort_re",   ram_re,  1);
            chk("abort_busy", busy,    0);
            chk("abort_fail", fail,    0);
            chk("abort_err",  err_cnt, 0);
            chk("abort_done", done,    0);
            @(posedge clk); #1 rst = 1'b0;
            return;
         end
         if (busy) busy_n++;
         if (s_busy) s_busy_n++;
         if (done && done_at < 0) done_at = c;
         if (s_done && s_done_at < 0) s_done_at = c;
         if (glitch_cyc >= 0 && c == glitch_cyc - 1) start = 1'b1;
         if (glitch_cyc >= 0 && c == glitch_cyc) start = 1'b0;
         case (c)
            0: begin
               chk("c0_addr", ram_addr, 6'h00);
               chk("c0_re",   ram_re,   0);
               chk("c0_data", ram_data, 8'h00);
               chk("c0_fail", fail,     0);
               chk("c0_err",  err_cnt,  0);
               chk("c0_diag", {fail_elem, fail_addr, fail_exp, fail_act}, 0);
            end
            64: begin
               chk("c64_addr", ram_addr, 6'h00);
               chk("c64_re",   ram_re,   1);
            end
            65: begin
               chk("c65_addr", ram_addr, 6'h00);
               chk("c65_re",   ram_re,   0);
               chk("c65_data", ram_data, 8'hFF);
            end
            320: begin
               chk("c320_addr", ram_addr, 6'h3F);
               chk("c320_re",   ram_re,   1);
            end
            703: begin
               chk("c703_addr", ram_addr, 6'h3F);
               chk("c703_re",   ram_re,   1);
               chk("c703_busy", busy,     1);
            end
            708: chk("done_re", ram_re, 1);
            default: ;
         endcase
      end
      chk("busy_len", busy_n,  704);
      chk("done_at",  done_at, 704);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; fault = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_re",   ram_re,   1);
      chk("rst_addr", ram_addr, 0);
      chk("rst_data", ram_data, 0);
      chk("rst_stat", {busy, done, pass, fail}, 0);
      chk("rst_err",  err_cnt,  0);
      chk("rst_diag", {fail_elem, fail_addr, fail_exp, fail_act}, 0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_re", ram_re, 1);

      // Clean run with address/op monitor
      run_test(-1, -1);
      chk("clean_pass", pass,    1);
      chk("clean_fail", fail,    0);
      chk("clean_err",  err_cnt, 0);
      chk("clean_done", done,    1);

      // Reset in the middle of a test, then a full clean run with a start glitch at cycle 100
      run_test(-1, 300);
      @(negedge clk);
      chk("post_rst_re", ram_re, 1);
      run_test(100, -1);
      chk("glitch_pass", pass, 1);

      // Stuck-at fault on both instances
      fault = 1'b1;
      run_test(-1, -1);
      chk("flt_fail",   fail,      1);
      chk("flt_pass",   pass,      0);
      chk("flt_err",    err_cnt,   3);
      chk("flt_elem",   fail_elem, 1);
      chk("flt_addr",   fail_addr, 6'h2A);
      chk("flt_exp",    fail_exp,  8'h00);
      chk("flt_act",    fail_act,  8'h01);
      chk("sof_done_at", s_done_at, 150);
      chk("sof_busy",   s_busy_n,  150);
      chk("sof_err",    s_err_cnt, 1);
      chk("sof_fail",   s_fail,    1);
      chk("sof_pass",   s_pass,    0);
      chk("sof_addr",   s_fail_addr, 6'h2A);

      // Restart on a clean RAM clears previous failure status
      fault = 1'b0;
      run_test(-1, -1);
      chk("rerun_pass", pass,    1);
      chk("rerun_fail", fail,    0);
      chk("rerun_err",  err_cnt, 0);
      chk("rerun_sof_pass", s_pass, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
